// File: rtl/rgst_file.sv
// rgst_file: parametrised register file with byte-masked write, two registered
// read ports and a pointer-swapped shadow bank for interrupt/context save.
//
// Parameters
//   WIDTH     data width in bits (multiple of 8)
//   DEPTH     words per bank (power of two, >= 2)
//   AW        address width, derived from DEPTH
//   RESET_VAL value loaded into every word of both banks on reset
//   BYPASS    1 = write-first on same-address read, 0 = read-first
//   R0_ZERO   1 = address 0 always reads as zero and ignores writes
//
// Ports
//   clk, rst           clock; synchronous active-high reset
//   we, waddr, wdata   write port (active bank)
//   wmask              byte enables, bit i covers wdata[8i+7:8i]
//   rd_en              update enable for both read registers
//   raddr_a, raddr_b   read addresses
//   rdata_a, rdata_b   registered read data (1-cycle latency)
//   swap               exchange active and shadow banks
//   bank               index of the active bank
module rgst_file #(
    parameter int                WIDTH     = 16,
    parameter int                DEPTH     = 8,
    parameter int                AW        = $clog2(DEPTH),
    parameter logic [WIDTH-1:0]  RESET_VAL = '0,
    parameter bit                BYPASS    = 1'b1,
    parameter bit                R0_ZERO   = 1'b1
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               we,
    input  logic [AW-1:0]      waddr,
    input  logic [WIDTH-1:0]   wdata,
    input  logic [WIDTH/8-1:0] wmask,
    input  logic               rd_en,
    input  logic [AW-1:0]      raddr_a,
    input  logic [AW-1:0]      raddr_b,
    output logic [WIDTH-1:0]   rdata_a,
    output logic [WIDTH-1:0]   rdata_b,
    input  logic               swap,
    output logic               bank
);

    localparam int NB = WIDTH / 8;

    logic [WIDTH-1:0] mem [2][DEPTH];
    logic             bank_q;
    logic [WIDTH-1:0] rdata_a_q;
    logic [WIDTH-1:0] rdata_b_q;

    logic [WIDTH-1:0] wr_old;
    logic [WIDTH-1:0] wr_new;
    logic             wr_ok;
    logic [WIDTH-1:0] rd_a;
    logic [WIDTH-1:0] rd_b;

    // Word as it will look after this cycle's write: written bytes from
    // wdata, the rest from the current contents.
    always_comb begin
        wr_old = mem[bank_q][waddr];
        wr_new = wr_old;
        for (int i = 0; i < NB; i++) begin
            if (wmask[i]) begin
                wr_new[8*i +: 8] = wdata[8*i +: 8];
            end
        end
    end

    // Address 0 is read-only when hardwired to zero; an all-zero mask
    // leaves the word untouched, so it is not treated as a write.
    always_comb begin
        wr_ok = we && (|wmask);
        if (R0_ZERO && (waddr == '0)) begin
            wr_ok = 1'b0;
        end
    end

    // Read-side selection. Both ports sample the pre-swap active bank.
    // With bypass, a same-address write is forwarded as the merged word.
    always_comb begin
        rd_a = mem[bank_q][raddr_a];
        if (BYPASS && wr_ok && (waddr == raddr_a)) begin
            rd_a = wr_new;
        end
        if (R0_ZERO && (raddr_a == '0)) begin
            rd_a = '0;
        end
    end

    always_comb begin
        rd_b = mem[bank_q][raddr_b];
        if (BYPASS && wr_ok && (waddr == raddr_b)) begin
            rd_b = wr_new;
        end
        if (R0_ZERO && (raddr_b == '0)) begin
            rd_b = '0;
        end
    end

    // Storage: the write targets the bank that is active before any swap
    // in the same cycle, so it ends up in the shadow bank after the swap.
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int b = 0; b < 2; b++) begin
                for (int i = 0; i < DEPTH; i++) begin
                    mem[b][i] <= RESET_VAL;
                end
            end
        end else if (wr_ok) begin
            mem[bank_q][waddr] <= wr_new;
        end
    end

    // Bank pointer and read registers.
    always_ff @(posedge clk) begin
        if (rst) begin
            bank_q    <= 1'b0;
            rdata_a_q <= '0;
            rdata_b_q <= '0;
        end else begin
            if (swap) begin
                bank_q <= ~bank_q;
            end
            if (rd_en) begin
                rdata_a_q <= rd_a;
                rdata_b_q <= rd_b;
            end
        end
    end

    assign rdata_a = rdata_a_q;
    assign rdata_b = rdata_b_q;
    assign bank    = bank_q;

endmodule

// File: tb/tb_rgst_file.sv
// tb_rgst_file: scoreboard bench for rgst_file, two configurations driven
// in lockstep (bypass/no-R0 and read-first/R0-zero), RESET_VAL = 16'h00A5.
module tb_rgst_file;

    localparam logic [15:0] RV = 16'h00A5;

    logic        clk = 1'b0;
    logic        rst;
    logic        we;
    logic [2:0]  waddr;
    logic [15:0] wdata;
    logic [1:0]  wmask;
    logic        rd_en;
    logic [2:0]  raddr_a;
    logic [2:0]  raddr_b;
    logic        swap;

    logic [15:0] ra0, rb0, ra1, rb1;
    logic        bk0, bk1;

    always #5 clk = ~clk;

    rgst_file #(
        .WIDTH(16), .DEPTH(8), .RESET_VAL(RV),
        .BYPASS(1'b1), .R0_ZERO(1'b0)
    ) u_byp (
        .clk(clk), .rst(rst), .we(we), .waddr(waddr),
        .wdata(wdata), .wmask(wmask), .rd_en(rd_en),
        .raddr_a(raddr_a), .raddr_b(raddr_b),
        .rdata_a(ra0), .rdata_b(rb0), .swap(swap), .bank(bk0)
    );

    rgst_file #(
        .WIDTH(16), .DEPTH(8), .RESET_VAL(RV),
        .BYPASS(1'b0), .R0_ZERO(1'b1)
    ) u_r0 (
        .clk(clk), .rst(rst), .we(we), .waddr(waddr),
        .wdata(wdata), .wmask(wmask), .rd_en(rd_en),
        .raddr_a(raddr_a), .raddr_b(raddr_b),
        .rdata_a(ra1), .rdata_b(rb1), .swap(swap), .bank(bk1)
    );

    typedef struct {
        logic [15:0] a;
        logic [15:0] b;
        logic        bk;
    } exp_t;

    exp_t q0[$];
    exp_t q1[$];
    exp_t last[2];

    logic [15:0] mm [2][2][8];
    logic        mbank [2];

    int n_cmp = 0;
    int n_err = 0;

    task automatic chk(input string tag, input logic [15:0] got,
                       input logic [15:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    function automatic bit r0z(input int c);
        return c == 1;
    endfunction

    function automatic bit byp(input int c);
        return c == 0;
    endfunction

    function automatic logic [15:0] merged(input logic [15:0] old);
        logic [15:0] nw;
        nw = old;
        for (int i = 0; i < 2; i++)
            if (wmask[i]) nw[8*i +: 8] = wdata[8*i +: 8];
        return nw;
    endfunction

    function automatic logic [15:0] rd_exp(input int c, input logic [2:0] a);
        logic [15:0] old;
        if (r0z(c) && a == 3'd0) return 16'h0;
        old = mm[c][mbank[c]][a];
        if (byp(c) && we && waddr == a) return merged(old);
        return old;
    endfunction

    // Predict, advance the model, clock the DUT, then pop and compare.
    task automatic step();
        exp_t e;
        for (int c = 0; c < 2; c++) begin
            if (rst) begin
                e = '{16'h0, 16'h0, 1'b0};
            end else begin
                e.a  = rd_en ? rd_exp(c, raddr_a) : last[c].a;
                e.b  = rd_en ? rd_exp(c, raddr_b) : last[c].b;
                e.bk = mbank[c] ^ swap;
            end
            last[c] = e;
            if (c == 0) q0.push_back(e);
            else        q1.push_back(e);
        end
        for (int c = 0; c < 2; c++) begin
            if (rst) begin
                for (int b = 0; b < 2; b++)
                    for (int i = 0; i < 8; i++)
                        mm[c][b][i] = RV;
                mbank[c] = 1'b0;
            end else begin
                if (we && !(r0z(c) && waddr == 3'd0))
                    mm[c][mbank[c]][waddr] = merged(mm[c][mbank[c]][waddr]);
                if (swap) mbank[c] = ~mbank[c];
            end
        end
        @(posedge clk);
        #1;
        e = q0.pop_front();
        chk("byp.rdata_a", ra0, e.a);
        chk("byp.rdata_b", rb0, e.b);
        chk("byp.bank", {15'h0, bk0}, {15'h0, e.bk});
        e = q1.pop_front();
        chk("r0.rdata_a", ra1, e.a);
        chk("r0.rdata_b", rb1, e.b);
        chk("r0.bank", {15'h0, bk1}, {15'h0, e.bk});
    endtask

    task automatic go(input logic r, input logic w, input logic [2:0] wa,
                      input logic [15:0] wd, input logic [1:0] wm,
                      input logic re, input logic [2:0] a,
                      input logic [2:0] b, input logic s);
        rst = r; we = w; waddr = wa; wdata = wd; wmask = wm;
        rd_en = re; raddr_a = a; raddr_b = b; swap = s;
        step();
    endtask

    initial begin
        rst = 1'b1; we = 1'b0; waddr = '0; wdata = '0; wmask = '0;
        rd_en = 1'b0; raddr_a = '0; raddr_b = '0; swap = 1'b0;

        // Reset held: rdata zero, bank zero.
        go(1, 0, 0, 0, 0, 1, 0, 0, 0);
        go(1, 1, 3, 16'hFFFF, 2'b11, 1, 3, 3, 1);
        chk("rst.rdata_a", ra0, 16'h0);
        chk("rst.bank", {15'h0, bk0}, 16'h0);

        // Reset contents on both ports.
        for (int i = 0; i < 8; i++) begin
            go(0, 0, 0, 0, 0, 1, 3'(i), 3'(7 - i), 0);
            chk("rv.byp", ra0, RV);
        end

        // Partial-mask write merge.
        go(0, 1, 3, 16'h1234, 2'b11, 0, 0, 0, 0);
        go(0, 1, 3, 16'hAB00, 2'b10, 0, 0, 0, 0);
        go(0, 0, 0, 0, 0, 1, 3, 3, 0);
        chk("merge.byp", ra0, 16'hAB34);
        chk("merge.r0", rb1, 16'hAB34);

        // Same-cycle write/read: bypass versus read-first.
        go(0, 1, 5, 16'h1111, 2'b11, 0, 0, 0, 0);
        go(0, 1, 5, 16'hBEEF, 2'b11, 1, 5, 5, 0);
        chk("bypass.new", ra0, 16'hBEEF);
        chk("readfirst.old", ra1, 16'h1111);

        // Address 0 write with same-cycle read, then re-read.
        go(0, 1, 0, 16'hFFFF, 2'b11, 1, 0, 0, 0);
        chk("r0.same_a", ra1, 16'h0);
        chk("r0.same_b", rb1, 16'h0);
        go(0, 0, 0, 0, 0, 1, 0, 0, 0);
        chk("r0.next", ra1, 16'h0);

        // Swap with a concurrent write into the outgoing bank.
        go(0, 1, 2, 16'h0001, 2'b11, 0, 0, 0, 0);
        go(0, 1, 2, 16'h0002, 2'b11, 0, 0, 0, 1);
        chk("swap.bank", {15'h0, bk0}, 16'h1);
        go(0, 0, 0, 0, 0, 1, 2, 2, 0);
        chk("swap.shadow", ra0, RV);
        go(0, 0, 0, 0, 0, 0, 0, 0, 1);
        go(0, 0, 0, 0, 0, 1, 2, 2, 0);
        chk("swap.back", rb1, 16'h0002);

        // Hold while rd_en is low.
        for (int i = 0; i < 6; i++)
            go(0, 1, 3'($urandom_range(0, 7)), 16'($urandom),
               2'($urandom), 0, 3'($urandom), 3'($urandom), 0);
        chk("hold.a", ra1, 16'h0002);

        // Back-to-back swaps, one with a read.
        go(0, 0, 0, 0, 0, 0, 0, 0, 1);
        go(0, 0, 0, 0, 0, 1, 2, 3, 1);
        go(0, 0, 0, 0, 0, 0, 0, 0, 1);

        // Random traffic, occasional reset.
        for (int i = 0; i < 300; i++)
            go(($urandom_range(0, 49) == 0), 1'($urandom),
               3'($urandom), 16'($urandom), 2'($urandom),
               1'($urandom), 3'($urandom), 3'($urandom),
               ($urandom_range(0, 5) == 0));

        // Reset overriding a write and a swap.
        go(0, 1, 4, 16'h5A5A, 2'b11, 1, 4, 4, 0);
        go(1, 1, 4, 16'hC3C3, 2'b11, 1, 4, 4, 1);
        chk("rst2.rdata", ra0, 16'h0);
        chk("rst2.bank", {15'h0, bk0}, 16'h0);
        for (int i = 0; i < 8; i++)
            go(0, 0, 0, 0, 0, 1, 3'(i), 3'(i), 0);
        chk("rst2.rv", rb0, RV);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***",
                 n_cmp, n_err);
        $finish;
    end

endmodule
